// File: rtl/io_mailbox.sv
// Bus-attached 32-bit mailbox: a word FIFO behind a four-register window, with
// sticky overflow/underflow flags and a threshold/overflow level interrupt.
module io_mailbox #(
  parameter logic [31:0] BASE_ADR = 32'hFFDC0000,
  parameter int          DEPTH    = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic        ack_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        irq_o
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [AW:0]     CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]     CNT_MAX = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t          state;
  logic [1:0]      rst_sync;
  logic            rst_n;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            ovf;
  logic            unf;
  logic            ien;
  logic            ovf_ien;
  logic [6:0]      thresh;

  logic            hit;
  logic            start;
  logic            any_sel;
  logic [1:0]      reg_sel;
  logic            full;
  logic            empty;
  logic            do_push;
  logic [6:0]      count7;
  logic [31:0]     rdata;
  logic            unused_adr;

  // Assertion is immediate; release is retimed to clk_i so no flop sees a runt recovery.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign hit        = cyc_i & stb_i & (adr_i[31:4] == BASE_ADR[31:4]);
  assign start      = (state == IDLE) & hit;
  assign any_sel    = |sel_i;
  assign reg_sel    = adr_i[3:2];
  assign full       = (count == CNT_MAX);
  assign empty      = (count == '0);
  assign count7     = 7'(count);
  assign do_push    = start & we_i & any_sel & (reg_sel == 2'd0) & ~full;
  assign ack_o      = (state == ACK) & stb_i;
  assign unused_adr = ^adr_i[1:0];

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      2'd0:    rdata = empty ? '0 : mem[rd_ptr];
      2'd1:    rdata = {20'd0, unf, ovf, full, empty, 1'b0, count7};
      2'd2:    rdata = {17'd0, thresh, 6'd0, ovf_ien, ien};
      default: rdata = '0;
    endcase
  end

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dat_o   <= '0;
      irq_o   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      ien     <= 1'b0;
      ovf_ien <= 1'b0;
      thresh  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= ACK;
            dat_o <= we_i ? '0 : rdata;
            if (we_i && any_sel) begin
              unique case (reg_sel)
                2'd0: begin
                  if (full) begin
                    ovf <= 1'b1;
                  end else begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    count  <= count + CNT_ONE;
                  end
                end
                2'd2: begin
                  if (sel_i[0]) {ovf_ien, ien} <= dat_i[1:0];
                  if (sel_i[1]) thresh <= dat_i[14:8];
                end
                2'd3: begin
                  if (dat_i[0]) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                  end
                  if (dat_i[1]) ovf <= 1'b0;
                  if (dat_i[2]) unf <= 1'b0;
                end
                default: ;
              endcase
            end else if (!we_i && reg_sel == 2'd0) begin
              if (empty) begin
                unf <= 1'b1;
              end else begin
                rd_ptr <= rd_ptr + PTR_ONE;
                count  <= count - CNT_ONE;
              end
            end
          end else begin
            dat_o <= '0;
          end
        end
        ACK: begin
          if (!stb_i || !cyc_i) begin
            state <= IDLE;
            dat_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
      irq_o <= (ien && thresh != 7'd0 && count7 >= thresh) || (ovf_ien && ovf);
    end
  end

endmodule

// File: tb/tb_io_mailbox.sv
// Directed and randomized bus traffic against io_mailbox, checked by a queue-based model.
module tb_io_mailbox;

  localparam logic [31:0] BASE  = 32'hFFDC0000;
  localparam int          DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        ack_o;
  logic        we_i = 1'b0;
  logic [3:0]  sel_i = 4'h0;
  logic [31:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        irq_o;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] q[$];
  bit          m_ovf, m_unf, m_ien, m_oien;
  int          m_thr;

  io_mailbox #(.BASE_ADR(BASE), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o),
    .we_i(we_i), .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    int n = q.size();
    return 32'(n) | (32'(n == 0) << 8) | (32'(n == DEPTH) << 9)
         | (32'(m_ovf) << 10) | (32'(m_unf) << 11);
  endfunction

  function automatic logic [31:0] m_ctrl();
    return (32'(m_thr) << 8) | (32'(m_oien) << 1) | 32'(m_ien);
  endfunction

  function automatic logic m_irq();
    return (m_ien && m_thr != 0 && q.size() >= m_thr) || (m_oien && m_ovf);
  endfunction

  function automatic void m_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_ien = 0; m_oien = 0; m_thr = 0;
  endfunction

  // One transaction, started at posedge+1; returns at posedge+1 after the ACK->IDLE edge.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                      input logic [3:0] sel, output logic [31:0] rd, output logic acked);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd; sel_i = sel;
    acked = 1'b0; rd = '0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk_i); #1;
      if (ack_o) begin acked = 1'b1; rd = dat_o; end
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic wr(input string tag, input int r, input logic [31:0] wd, input logic [3:0] sel);
    logic [31:0] rd; logic acked;
    xfer(1'b1, BASE | 32'(r << 2) | 32'($urandom_range(0, 3)), wd, sel, rd, acked);
    check({tag, "_ack"}, 32'(acked), 32'd1);
    check({tag, "_wdat"}, rd, 32'd0);
    if (sel != 4'h0) begin
      case (r)
        0: if (q.size() == DEPTH) m_ovf = 1; else q.push_back(wd);
        2: begin
          if (sel[0]) begin m_ien = wd[0]; m_oien = wd[1]; end
          if (sel[1]) m_thr = int'(wd[14:8]);
        end
        3: begin
          if (wd[0]) q.delete();
          if (wd[1]) m_ovf = 0;
          if (wd[2]) m_unf = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic rd_chk(input string tag, input int r);
    logic [31:0] rd, exp; logic acked;
    case (r)
      0: begin
        if (q.size() == 0) begin m_unf = 1; exp = '0; end
        else exp = q.pop_front();
      end
      1: exp = m_status();
      2: exp = m_ctrl();
      default: exp = '0;
    endcase
    xfer(1'b0, BASE | 32'(r << 2), 32'($urandom), 4'hF, rd, acked);
    check({tag, "_ack"}, 32'(acked), 32'd1);
    check(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] rd, w;
    logic acked;
    int acks;
    m_reset();

    // Reset state
    repeat (2) @(posedge clk_i); #1;
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i); #1;
    rd_chk("rst_status", 1);
    rd_chk("rst_ctrl", 2);

    // Two words in order
    wr("p1", 0, 32'h11111111, 4'hF);
    wr("p2", 0, 32'h22222222, 4'hF);
    check("st2_const", m_status(), 32'h00000002);
    rd_chk("st2", 1);
    rd_chk("pop1", 0);
    rd_chk("pop2", 0);
    check("st0_const", m_status(), 32'h00000100);
    rd_chk("st0", 1);

    // Overflow on 17th push
    for (int i = 0; i < 17; i++) wr("fill", 0, $urandom, 4'hF);
    check("ovf_const", m_status(), 32'h00000610);
    rd_chk("ovf_status", 1);
    for (int i = 0; i < 16; i++) rd_chk("drain", 0);
    wr("clr_ovf", 3, 32'h2, 4'hF);
    rd_chk("ovf_cleared", 1);

    // Empty read with strobe held five cycles
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = BASE; sel_i = 4'hF;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk_i); #1; end
      if (ack_o) acks++;
      if (i > 0) check("unf_dat", dat_o, 32'd0);
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    @(posedge clk_i); #1;
    m_unf = 1;
    check("hold_acks", 32'(acks), 32'd4);
    check("unf_const", m_status(), 32'h00000900);
    rd_chk("unf_status", 1);
    // Held strobe on a non-empty FIFO must pop once only
    wr("h1", 0, 32'hA5A5A5A5, 4'hF);
    wr("h2", 0, 32'h5A5A5A5A, 4'hF);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = BASE; sel_i = 4'hF;
    repeat (5) @(posedge clk_i); #1;
    check("hold_pop_dat", dat_o, 32'hA5A5A5A5);
    cyc_i = 1'b0; stb_i = 1'b0;
    @(posedge clk_i); #1;
    void'(q.pop_front());
    rd_chk("hold_pop_status", 1);
    wr("clr_all", 3, 32'h7, 4'hF);
    rd_chk("clr_all_status", 1);

    // Threshold interrupt
    wr("ctrl_thr", 2, 32'h00000401, 4'hF);
    for (int i = 0; i < 3; i++) begin
      wr("thr_push", 0, $urandom, 4'hF);
      check("irq_below", 32'(irq_o), 32'd0);
    end
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = BASE; dat_i = 32'hCAFE0004; sel_i = 4'hF;
    @(posedge clk_i); #1;
    check("irq_one_after", 32'(irq_o), 32'd0);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); #1;
    q.push_back(32'hCAFE0004);
    check("irq_two_after", 32'(irq_o), 32'd1);
    rd_chk("thr_pop", 0);
    check("irq_after_pop", 32'(irq_o), 32'(m_irq()));
    check("irq_after_pop_const", 32'(irq_o), 32'd0);

    // Byte-lane CTRL write, sel=0 and STATUS writes, out-of-window access
    wr("ctrl_zero", 2, 32'h0, 4'hF);
    wr("ctrl_lane1", 2, 32'hFFFFFFFF, 4'b0010);
    check("ctrl_lane_const", m_ctrl(), 32'h00007F00);
    rd_chk("ctrl_lane", 2);
    wr("sel0_push", 0, 32'hDEADBEEF, 4'h0);
    wr("sel0_clr", 3, 32'h1, 4'h0);
    wr("status_wr", 1, 32'hFFFFFFFF, 4'hF);
    rd_chk("after_noop_status", 1);
    xfer(1'b1, BASE + 32'd16, 32'h12345678, 4'hF, rd, acked);
    check("outside_noack", 32'(acked), 32'd0);
    xfer(1'b0, BASE - 32'd4, 32'h0, 4'hF, rd, acked);
    check("outside_rd_noack", 32'(acked), 32'd0);
    rd_chk("outside_status", 1);
    rd_chk("clr_reads0", 3);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int op = $urandom_range(0, 11);
      if (op <= 3)       wr("r_push", 0, $urandom, 4'($urandom_range(1, 15)));
      else if (op <= 6)  rd_chk("r_pop", 0);
      else if (op == 7)  rd_chk("r_status", 1);
      else if (op == 8)  wr("r_ctrl", 2, {17'($urandom), 7'($urandom_range(0, DEPTH + 2)),
                                          8'($urandom)}, 4'($urandom));
      else if (op == 9)  rd_chk("r_ctrl_rd", 2);
      else if (op == 10) wr("r_clr", 3, ($urandom_range(0, 5) == 0) ? 32'h7 : 32'($urandom_range(0, 6)),
                            4'($urandom));
      else               wr("r_st_wr", 1, $urandom, 4'hF);
      check("r_irq", 32'(irq_o), 32'(m_irq()));
    end
    rd_chk("r_final_status", 1);

    // Reset during ACK with words queued
    wr("pre_rst_clr", 3, 32'h7, 4'hF);
    wr("pre_rst_ctrl", 2, 32'h00000401, 4'hF);
    for (int i = 0; i < 5; i++) wr("pre_rst_push", 0, $urandom, 4'hF);
    check("pre_rst_irq", 32'(irq_o), 32'd1);
    w = q[0];
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = BASE; sel_i = 4'hF;
    @(posedge clk_i); #1;
    check("mid_ack", 32'(ack_o), 32'd1);
    check("mid_dat", dat_o, w);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_ack", 32'(ack_o), 32'd0);
    check("rst_mid_irq", 32'(irq_o), 32'd0);
    check("rst_mid_dat", dat_o, 32'd0);
    cyc_i = 1'b0; stb_i = 1'b0;
    m_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i); #1;
    check("post_rst_const", m_status(), 32'h00000100);
    rd_chk("post_rst_status", 1);
    rd_chk("post_rst_ctrl", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
